// File: rtl/uart_shift_pkg.sv
// Shared types and helpers for the UART shift engine.
package uart_shift_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam logic SERIAL_IDLE = 1'b1;

  // A zero or oversize frame length selects the full register width.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned width);
    return (len == 0 || len > width) ? width : len;
  endfunction

endpackage

// File: rtl/uart_shift_bit_counter.sv
// Bit counter with terminal-count compare for the shift engine.
// With UART_SHIFT_PARITY_EN the terminal count includes the parity stage.
module uart_shift_bit_counter #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [LEN_W-1:0] len,
`ifdef UART_SHIFT_PARITY_EN
  output logic             data_end,
`endif
  output logic             at_end
);

  logic [LEN_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + LEN_W'(1);
    end
  end

`ifdef UART_SHIFT_PARITY_EN
  assign data_end = (cnt == len - LEN_W'(1));
  assign at_end   = (cnt == len);
`else
  assign at_end   = (cnt == len - LEN_W'(1));
`endif

endmodule

// File: rtl/uart_shift_engine.sv
// Full-duplex shift/parallel-load engine for the UART datapath.
// Optional parity stage enabled by defining UART_SHIFT_PARITY_EN.
module uart_shift_engine
  import uart_shift_pkg::*;
#(
  parameter int DATA_WIDTH = 9,
  parameter int LEN_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0]      frame_len,
  input  logic                  msb_first,
  input  logic                  shift_tick,
  input  logic                  abort,
  input  logic                  serial_in,
`ifdef UART_SHIFT_PARITY_EN
  input  logic                  parity_odd,
  output logic                  parity_err,
`endif
  output logic                  serial_out,
  output logic                  busy,
  output logic                  cap_valid,
  output logic [DATA_WIDTH-1:0] cap_data,
  output logic                  done
);

  state_t                state, next_state;
  logic [DATA_WIDTH-1:0] shreg, shifted, load_word;
  logic [LEN_W-1:0]      len_q, load_len;
  logic                  msb_q;
  logic                  load_fire, step, finish, at_end;

  function automatic logic [DATA_WIDTH-1:0] len_mask(input logic [LEN_W-1:0] n);
    return ~({DATA_WIDTH{1'b1}} << n);
  endfunction

  function automatic logic cur_bit(input logic [DATA_WIDTH-1:0] w,
                                   input logic [LEN_W-1:0] n, input logic m);
    return m ? w[n - LEN_W'(1)] : w[0];
  endfunction

  assign load_len  = LEN_W'(clamp_len(32'(frame_len), DATA_WIDTH));
  assign load_word = load_data & len_mask(load_len);

  // Shifting stays inside the len-bit window; received bits enter at the far end.
  always_comb begin
    if (msb_q) begin
      shifted = ((shreg << 1) & len_mask(len_q)) | DATA_WIDTH'(serial_in);
    end else begin
      shifted = (shreg >> 1) | (DATA_WIDTH'(serial_in) << (len_q - LEN_W'(1)));
    end
  end

`ifdef UART_SHIFT_PARITY_EN
  logic par_odd_q, par_tx_q, data_end;
`endif

  uart_shift_bit_counter #(
    .LEN_W(LEN_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (load_fire),
    .en      (step),
    .len     (len_q),
`ifdef UART_SHIFT_PARITY_EN
    .data_end(data_end),
`endif
    .at_end  (at_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load_ready = 1'b0;
    busy       = 1'b0;
    load_fire  = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          load_fire  = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (abort) begin
          next_state = IDLE;
        end else if (shift_tick) begin
          step = 1'b1;
          if (at_end) begin
            finish     = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg      <= '0;
      len_q      <= '0;
      msb_q      <= 1'b0;
      serial_out <= SERIAL_IDLE;
      cap_valid  <= 1'b0;
      cap_data   <= '0;
      done       <= 1'b0;
`ifdef UART_SHIFT_PARITY_EN
      par_odd_q  <= 1'b0;
      par_tx_q   <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      cap_valid <= 1'b0;
      done      <= 1'b0;
      if (load_fire) begin
        shreg      <= load_word;
        len_q      <= load_len;
        msb_q      <= msb_first;
        serial_out <= cur_bit(load_word, load_len, msb_first);
`ifdef UART_SHIFT_PARITY_EN
        par_odd_q  <= parity_odd;
        par_tx_q   <= (^load_word) ^ parity_odd;
`endif
      end else if (state == SHIFT && abort) begin
        serial_out <= SERIAL_IDLE;
      end else if (finish) begin
        cap_valid  <= 1'b1;
        done       <= 1'b1;
        serial_out <= SERIAL_IDLE;
`ifdef UART_SHIFT_PARITY_EN
        // Parity tick: shreg already holds the full received word.
        cap_data   <= shreg;
        parity_err <= serial_in != ((^shreg) ^ par_odd_q);
`else
        shreg      <= shifted;
        cap_data   <= shifted;
`endif
      end else if (step) begin
        shreg      <= shifted;
`ifdef UART_SHIFT_PARITY_EN
        serial_out <= data_end ? par_tx_q : cur_bit(shifted, len_q, msb_q);
`else
        serial_out <= cur_bit(shifted, len_q, msb_q);
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_shift_engine.sv
// Directed self-checking bench for uart_shift_engine (DATA_WIDTH 9).
module tb_uart_shift_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [8:0] load_data = '0;
  logic [3:0] frame_len = '0;
  logic       msb_first = 1'b0;
  logic       shift_tick = 1'b0;
  logic       abort = 1'b0;
  logic       serial_in = 1'b1;
  logic       serial_out, busy, cap_valid, done;
  logic [8:0] cap_data;
`ifdef UART_SHIFT_PARITY_EN
  logic       parity_odd = 1'b0;
  logic       parity_err;
`endif

  int total = 0;
  int bad = 0;

  logic [15:0] seen;
  int          early;
  logic        cl, dl;

  uart_shift_engine #(.DATA_WIDTH(9)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .frame_len (frame_len),
    .msb_first (msb_first),
    .shift_tick(shift_tick),
    .abort     (abort),
    .serial_in (serial_in),
`ifdef UART_SHIFT_PARITY_EN
    .parity_odd(parity_odd),
    .parity_err(parity_err),
`endif
    .serial_out(serial_out),
    .busy      (busy),
    .cap_valid (cap_valid),
    .cap_data  (cap_data),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [8:0] d, input logic [3:0] fl, input logic m);
    load_data = d; frame_len = fl; msb_first = m; load_valid = 1'b1;
    cycle();
    load_valid = 1'b0;
  endtask

  // Ticks every 4th cycle; records serial_out before each tick and any stray pulses.
  task automatic run_ticks(input int n, input bit loop, input logic fixed,
                           output logic [15:0] s, output int e, output logic c, output logic d);
    s = '0; e = 0; c = 1'b0; d = 1'b0;
    for (int i = 0; i < n; i++) begin
      repeat (3) begin
        cycle();
        if (cap_valid || done) e++;
      end
      s[i] = serial_out;
      serial_in = loop ? serial_out : fixed;
      shift_tick = 1'b1;
      cycle();
      shift_tick = 1'b0;
      if (i == n - 1) begin
        c = cap_valid; d = done;
      end else if (cap_valid || done) begin
        e++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) cycle();
    total++; if (serial_out !== 1'b1) begin bad++; $display("FAIL reset_serial_out: got %b want 1", serial_out); end
    total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL reset_load_ready: got %b want 1", load_ready); end
    total++; if ({busy, done, cap_valid} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {busy, done, cap_valid}); end
    total++; if (cap_data !== 9'h000) begin bad++; $display("FAIL reset_cap_data: got %h want 000", cap_data); end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_lsb_loopback();
    do_load(9'h0A5, 4'd8, 1'b0);
    total++; if ({busy, load_ready} !== 2'b10) begin bad++; $display("FAIL t1_busy: got %b want 10", {busy, load_ready}); end
    run_ticks(8, 1'b1, 1'b0, seen, early, cl, dl);
    total++; if (seen[7:0] !== 8'hA5) begin bad++; $display("FAIL t1_bits: got %h want a5", seen[7:0]); end
    total++; if ({cl, dl, early} !== {1'b1, 1'b1, 32'd0}) begin bad++; $display("FAIL t1_pulse: cap %b done %b early %0d want 1 1 0", cl, dl, early); end
    total++; if (cap_data !== 9'h0A5) begin bad++; $display("FAIL t1_cap: got %h want 0a5", cap_data); end
    total++; if ({serial_out, busy} !== 2'b10) begin bad++; $display("FAIL t1_end: got %b want 10", {serial_out, busy}); end
    cycle();
    total++; if ({cap_valid, done} !== 2'b00) begin bad++; $display("FAIL t1_one_shot: got %b want 00", {cap_valid, done}); end
  endtask

  task automatic test_msb_fixed_in();
    do_load(9'h1B3, 4'd9, 1'b1);
    run_ticks(9, 1'b0, 1'b0, seen, early, cl, dl);
    total++; if (seen[8:0] !== 9'h19B) begin bad++; $display("FAIL t2_bits: got %h want 19b", seen[8:0]); end
    total++; if ({cl, dl, early} !== {1'b1, 1'b1, 32'd0}) begin bad++; $display("FAIL t2_pulse: cap %b done %b early %0d want 1 1 0", cl, dl, early); end
    total++; if (cap_data !== 9'h000) begin bad++; $display("FAIL t2_cap: got %h want 000", cap_data); end
  endtask

  task automatic test_frame_len();
    do_load(9'h1FF, 4'd5, 1'b0);
    run_ticks(5, 1'b1, 1'b0, seen, early, cl, dl);
    total++; if (seen[4:0] !== 5'h1F || cl !== 1'b1 || early != 0) begin bad++; $display("FAIL t3_len5_bits: got %h cap %b early %0d want 1f 1 0", seen[4:0], cl, early); end
    total++; if (cap_data !== 9'h01F) begin bad++; $display("FAIL t3_len5_cap: got %h want 01f", cap_data); end
    do_load(9'h1F6, 4'd5, 1'b1);
    run_ticks(5, 1'b1, 1'b0, seen, early, cl, dl);
    total++; if (seen[4:0] !== 5'h0D || cl !== 1'b1 || early != 0) begin bad++; $display("FAIL t3_msb5_bits: got %h cap %b early %0d want 0d 1 0", seen[4:0], cl, early); end
    total++; if (cap_data !== 9'h016) begin bad++; $display("FAIL t3_msb5_cap: got %h want 016", cap_data); end
    do_load(9'h155, 4'd0, 1'b0);
    run_ticks(9, 1'b1, 1'b0, seen, early, cl, dl);
    total++; if (seen[8:0] !== 9'h155 || cl !== 1'b1 || early != 0) begin bad++; $display("FAIL t3_len0: got %h cap %b early %0d want 155 1 0", seen[8:0], cl, early); end
    total++; if (cap_data !== 9'h155) begin bad++; $display("FAIL t3_len0_cap: got %h want 155", cap_data); end
    do_load(9'h0C3, 4'd12, 1'b1);
    run_ticks(9, 1'b1, 1'b0, seen, early, cl, dl);
    total++; if (seen[8:0] !== 9'h186 || cl !== 1'b1 || early != 0) begin bad++; $display("FAIL t3_len12: got %h cap %b early %0d want 186 1 0", seen[8:0], cl, early); end
    total++; if (cap_data !== 9'h0C3) begin bad++; $display("FAIL t3_len12_cap: got %h want 0c3", cap_data); end
    do_load(9'h001, 4'd1, 1'b0);
    run_ticks(1, 1'b0, 1'b1, seen, early, cl, dl);
    total++; if ({seen[0], cl, dl} !== 3'b111) begin bad++; $display("FAIL t3_len1: got %b want 111", {seen[0], cl, dl}); end
    total++; if (cap_data !== 9'h001) begin bad++; $display("FAIL t3_len1_cap: got %h want 001", cap_data); end
  endtask

  task automatic test_abort();
    do_load(9'h0F0, 4'd8, 1'b0);
    run_ticks(3, 1'b1, 1'b0, seen, early, cl, dl);
    abort = 1'b1; shift_tick = 1'b1;
    cycle();
    abort = 1'b0; shift_tick = 1'b0;
    total++; if ({busy, load_ready, serial_out} !== 3'b011) begin bad++; $display("FAIL t4_abort_state: got %b want 011", {busy, load_ready, serial_out}); end
    total++; if ({cap_valid, done, cl, dl} !== 4'b0000) begin bad++; $display("FAIL t4_abort_pulse: got %b want 0000", {cap_valid, done, cl, dl}); end
    total++; if (cap_data !== 9'h001) begin bad++; $display("FAIL t4_cap_hold: got %h want 001", cap_data); end
    run_ticks(4, 1'b0, 1'b0, seen, early, cl, dl);
    total++; if ({busy, cl, serial_out} !== 3'b001 || early != 0) begin bad++; $display("FAIL t4_idle_ticks: got %b early %0d want 001 0", {busy, cl, serial_out}, early); end
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    total++; if ({load_ready, serial_out, cap_data} !== {2'b11, 9'h001}) begin bad++; $display("FAIL t4_idle_abort: got %b %h want 11 001", {load_ready, serial_out}, cap_data); end
    do_load(9'h02A, 4'd6, 1'b0);
    run_ticks(6, 1'b1, 1'b0, seen, early, cl, dl);
    total++; if (cap_data !== 9'h02A || cl !== 1'b1) begin bad++; $display("FAIL t4_recover: got %h cap %b want 02a 1", cap_data, cl); end
  endtask

  task automatic test_back_to_back();
    load_data = 9'h0A5; frame_len = 4'd4; msb_first = 1'b0; load_valid = 1'b1; shift_tick = 1'b1;
    cycle();
    shift_tick = 1'b0;
    load_data = 9'h003; frame_len = 4'd3;
    total++; if ({busy, load_ready, serial_out} !== 3'b101) begin bad++; $display("FAIL t5_loaded: got %b want 101", {busy, load_ready, serial_out}); end
    run_ticks(3, 1'b1, 1'b0, seen, early, cl, dl);
    total++; if (seen[2:0] !== 3'b101 || {cl, dl, busy} !== 3'b001 || early != 0) begin bad++; $display("FAIL t5_tick_ignored: got %b %b early %0d want 101 001 0", seen[2:0], {cl, dl, busy}, early); end
    run_ticks(1, 1'b1, 1'b0, seen, early, cl, dl);
    total++; if ({cl, dl, busy, load_ready} !== 4'b1101 || cap_data !== 9'h005) begin bad++; $display("FAIL t5_first_done: got %b %h want 1101 005", {cl, dl, busy, load_ready}, cap_data); end
    cycle();
    load_valid = 1'b0;
    total++; if ({busy, serial_out} !== 2'b11) begin bad++; $display("FAIL t5_second_load: got %b want 11", {busy, serial_out}); end
    run_ticks(3, 1'b1, 1'b0, seen, early, cl, dl);
    total++; if (cap_data !== 9'h003 || cl !== 1'b1 || early != 0) begin bad++; $display("FAIL t5_second_cap: got %h cap %b early %0d want 003 1 0", cap_data, cl, early); end
  endtask

`ifdef UART_SHIFT_PARITY_EN
  task automatic test_parity();
    parity_odd = 1'b0;
    do_load(9'h007, 4'd8, 1'b0);
    run_ticks(8, 1'b1, 1'b0, seen, early, cl, dl);
    total++; if ({cl, serial_out, busy} !== 3'b011) begin bad++; $display("FAIL t6_parity_bit: got %b want 011", {cl, serial_out, busy}); end
    run_ticks(1, 1'b1, 1'b0, seen, early, cl, dl);
    total++; if ({cl, dl, parity_err} !== 3'b110 || cap_data !== 9'h007) begin bad++; $display("FAIL t6_parity_ok: got %b %h want 110 007", {cl, dl, parity_err}, cap_data); end
    do_load(9'h007, 4'd8, 1'b0);
    run_ticks(8, 1'b1, 1'b0, seen, early, cl, dl);
    run_ticks(1, 1'b0, 1'b0, seen, early, cl, dl);
    total++; if ({cl, parity_err} !== 2'b11 || cap_data !== 9'h007) begin bad++; $display("FAIL t6_parity_err: got %b %h want 11 007", {cl, parity_err}, cap_data); end
  endtask
`endif

  task automatic test_reset_mid_frame();
    do_load(9'h0FF, 4'd8, 1'b0);
    run_ticks(2, 1'b1, 1'b0, seen, early, cl, dl);
    rst = 1'b1; shift_tick = 1'b1;
    cycle();
    rst = 1'b0; shift_tick = 1'b0;
    total++; if ({busy, load_ready, serial_out, cap_valid, done} !== 5'b01100) begin bad++; $display("FAIL rst_mid_flags: got %b want 01100", {busy, load_ready, serial_out, cap_valid, done}); end
    total++; if (cap_data !== 9'h000) begin bad++; $display("FAIL rst_mid_cap: got %h want 000", cap_data); end
  endtask

  initial begin
    test_reset();
    test_lsb_loopback();
    test_msb_fixed_in();
    test_frame_len();
    test_abort();
    test_back_to_back();
`ifdef UART_SHIFT_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
